// File: rtl/io_port_pkg.sv
// Shared constants and interrupt FSM encoding for the CPU I/O port controller.
package io_port_pkg;

  localparam int unsigned InDepthDefault  = 4;
  localparam int unsigned OutDepthDefault = 4;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAssert  = 2'd1,
    StService = 2'd2
  } int_state_e;

endpackage

// File: rtl/io_port_if.sv
// Port bundle between the I/O controller (slave) and the CPU/external side (master).
interface io_port_if;
  logic [7:0] ext_in_data;
  logic       ext_in_valid;
  logic       ext_in_ready;
  logic [7:0] cpu_i_port;
  logic       cpu_in_rd;
  logic [7:0] cpu_o_port;
  logic       cpu_io_wr;
  logic [7:0] ext_out_data;
  logic       ext_out_valid;
  logic       ext_out_ready;
  logic       int_sig;
  logic       int_ack;
  logic       ovf_err;

  modport slave (
    input  ext_in_data, ext_in_valid, cpu_in_rd, cpu_o_port, cpu_io_wr, ext_out_ready, int_ack,
    output ext_in_ready, cpu_i_port, ext_out_data, ext_out_valid, int_sig, ovf_err
  );

  modport master (
    output ext_in_data, ext_in_valid, cpu_in_rd, cpu_o_port, cpu_io_wr, ext_out_ready, int_ack,
    input  ext_in_ready, cpu_i_port, ext_out_data, ext_out_valid, int_sig, ovf_err
  );
endinterface

// File: rtl/io_sync_fifo.sv
// Byte-wide synchronous FIFO; head reads as 8'h00 while empty.
module io_sync_fifo #(
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [7:0]             wdata_i,
  output logic [7:0]             rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [7:0]      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  // A push while full is refused even when a pop happens in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/io_port_ctrl.sv
// CPU I/O port controller: input FIFO with interrupt FSM, output store with sticky overflow.
// Define IO_PORT_OUT_FIFO_EN for an OUT_DEPTH-entry output FIFO; otherwise a single holding register.
module io_port_ctrl
  import io_port_pkg::*;
#(
  parameter int unsigned IN_DEPTH  = InDepthDefault,
  parameter int unsigned OUT_DEPTH = OutDepthDefault
) (
  input logic     clk,
  input logic     rstn,
  io_port_if.slave bus
);

  if (IN_DEPTH < 2 || IN_DEPTH > 16 || (IN_DEPTH & (IN_DEPTH - 1)) != 0) begin : g_bad_in_depth
    $error("IN_DEPTH must be a power of two in 2..16");
  end
  if (OUT_DEPTH < 2 || OUT_DEPTH > 16 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : g_bad_out_depth
    $error("OUT_DEPTH must be a power of two in 2..16");
  end

  // Input path
  logic                      in_full, in_empty, in_push, rdy_q;
  logic [$clog2(IN_DEPTH):0] in_count;

  // Holds ext_in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rdy_q <= 1'b0;
    else       rdy_q <= 1'b1;
  end

  assign bus.ext_in_ready = rdy_q & ~in_full;
  assign in_push          = bus.ext_in_valid & bus.ext_in_ready;

  io_sync_fifo #(
    .Depth (IN_DEPTH)
  ) u_in_fifo (
    .clk_i   (clk),
    .rst_ni  (rstn),
    .push_i  (in_push),
    .pop_i   (bus.cpu_in_rd),
    .wdata_i (bus.ext_in_data),
    .rdata_o (bus.cpu_i_port),
    .full_o  (in_full),
    .empty_o (in_empty),
    .count_o (in_count)
  );

  // Interrupt FSM
  int_state_e state_q, state_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (in_count != '0) state_d = StAssert;
      StAssert:  if (bus.int_ack)    state_d = StService;
      StService: if (in_empty)       state_d = StIdle;
      default:                       state_d = StIdle;
    endcase
  end

  assign bus.int_sig = (state_q == StAssert);

  // Output path
  logic out_full, ovf_q;

`ifdef IO_PORT_OUT_FIFO_EN
  logic                       out_empty;
  logic [$clog2(OUT_DEPTH):0] out_count;

  io_sync_fifo #(
    .Depth (OUT_DEPTH)
  ) u_out_fifo (
    .clk_i   (clk),
    .rst_ni  (rstn),
    .push_i  (bus.cpu_io_wr),
    .pop_i   (bus.ext_out_ready),
    .wdata_i (bus.cpu_o_port),
    .rdata_o (bus.ext_out_data),
    .full_o  (out_full),
    .empty_o (out_empty),
    .count_o (out_count)
  );

  assign bus.ext_out_valid = (out_count != '0) & ~out_empty;
`else
  logic [7:0] hold_q;
  logic       hold_vld_q;

  assign out_full          = hold_vld_q;
  assign bus.ext_out_valid = hold_vld_q;
  assign bus.ext_out_data  = hold_vld_q ? hold_q : 8'h00;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_q     <= 8'h00;
      hold_vld_q <= 1'b0;
    end else if (bus.cpu_io_wr && !hold_vld_q) begin
      hold_q     <= bus.cpu_o_port;
      hold_vld_q <= 1'b1;
    end else if (hold_vld_q && bus.ext_out_ready) begin
      hold_vld_q <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ovf_q <= 1'b0;
    else       ovf_q <= ovf_q | (bus.cpu_io_wr & out_full);
  end

  assign bus.ovf_err = ovf_q;

endmodule

// File: doc/io_port_ctrl.md
IO_PORT_CTRL -- requirements
Module: io_port_ctrl

Interface
REQ-001 SHALL have parameter IN_DEPTH, default 4, meaning input FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter OUT_DEPTH, default 4, meaning output FIFO entries (power of two, 2..16); used only when IO_PORT_OUT_FIFO_EN is defined.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstn, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port ext_in_data, input, 8, byte from the external producer.
REQ-006 SHALL have port ext_in_valid, input, 1, producer byte valid.
REQ-007 SHALL have port ext_in_ready, output, 1, input FIFO can accept a byte.
REQ-008 SHALL have port cpu_i_port, output, 8, drives the CPU input port.
REQ-009 SHALL have port cpu_in_rd, input, 1, CPU consumed the cpu_i_port byte this cycle.
REQ-010 SHALL have port cpu_o_port, input, 8, CPU output-port value.
REQ-011 SHALL have port cpu_io_wr, input, 1, CPU output-port write strobe.
REQ-012 SHALL have port ext_out_data, output, 8, byte to the external consumer.
REQ-013 SHALL have port ext_out_valid, output, 1, ext_out_data valid.
REQ-014 SHALL have port ext_out_ready, input, 1, consumer accepts the byte.
REQ-015 SHALL have port int_sig, output, 1, interrupt request to the CPU.
REQ-016 SHALL have port int_ack, input, 1, CPU interrupt acknowledge.
REQ-017 SHALL have port ovf_err, output, 1, sticky output-overflow flag.

Function
REQ-018 SHALL push ext_in_data into the input FIFO on a rising edge with ext_in_valid=1 and ext_in_ready=1; ext_in_ready = not full.
REQ-019 SHALL drive cpu_i_port with the input-FIFO head when non-empty and 8'h00 when empty; a byte pushed at edge N appears from edge N onward (visible in cycle N+1).
REQ-020 SHALL pop the input FIFO on cpu_in_rd=1 when non-empty; cpu_in_rd while empty is ignored.
REQ-021 SHALL keep the count unchanged on simultaneous push and pop; a push while full is refused even if a pop occurs the same cycle.
REQ-022 SHALL wrap read/write pointers modulo depth, with count width log2(depth)+1.
REQ-023 SHALL run an interrupt FSM: IDLE -> ASSERT when input count > 0; ASSERT -> SERVICE on int_ack=1; SERVICE -> IDLE when count reaches 0.
REQ-024 SHALL register int_sig high only in ASSERT: byte pushed at edge N gives int_sig=1 from edge N+1.
REQ-025 SHALL ignore int_ack in IDLE and SERVICE; new bytes arriving in SERVICE extend SERVICE and do not re-raise int_sig.
REQ-026 SHALL accept cpu_o_port on cpu_io_wr=1 into the output store when not full; when full, drop the write and set ovf_err to 1 until reset.
REQ-027 SHALL present the output-store head on ext_out_data with ext_out_valid = not empty, popping on ext_out_valid and ext_out_ready; when empty, ext_out_data = 8'h00.
REQ-028 SHALL allow a CPU write and an external pop in the same cycle when non-empty, leaving the count unchanged.

Reset
REQ-029 SHALL, while rstn=0, immediately clear both FIFOs and pointers and set FSM to IDLE, int_sig=0, ovf_err=0, ext_in_ready=0, ext_out_valid=0, cpu_i_port=8'h00, ext_out_data=8'h00.
REQ-030 SHALL drive ext_in_ready=1 from the first edge after rstn deasserts; reset mid-transfer discards all buffered bytes.

Configuration
REQ-031 SHALL, with IO_PORT_OUT_FIFO_EN defined, implement the output store as an OUT_DEPTH-entry FIFO.
REQ-032 SHALL, without IO_PORT_OUT_FIFO_EN, implement the output store as a single holding register (full = valid), with identical drop/ovf_err rules.

Structure
REQ-033 SHALL place the FSM state encoding (IDLE=2'd0, ASSERT=2'd1, SERVICE=2'd2) and the default depth constants in shared package io_port_pkg.
REQ-034 SHALL implement both buffers with one sub-module, io_sync_fifo (parameterised depth, 8-bit data, full/empty/count outputs).

Verification
REQ-035 SHALL cover: push 8'hA5 with CPU idle -> cpu_i_port=8'hA5 next cycle, int_sig=1 one edge later, held until int_ack.
REQ-036 SHALL cover: push 4 bytes with no reads (IN_DEPTH=4) -> ext_in_ready=0; a 5th valid byte is not stored; reads return bytes in order.
REQ-037 SHALL cover: int_ack, then two cpu_in_rd pops of 2 bytes -> SERVICE then IDLE, int_sig=0 throughout SERVICE; a new byte then re-raises int_sig.
REQ-038 SHALL cover: cpu_io_wr of 8'h3C with ext_out_ready=0, then filling -> excess write is dropped and ovf_err=1; draining yields 8'h3C first.
REQ-039 SHALL cover: simultaneous push and pop at count 2 -> count stays 2; rstn pulsed low mid-stream -> all outputs take reset values asynchronously.
REQ-040 SHALL cover both builds, with and without IO_PORT_OUT_FIFO_EN: without it, a second write before a pop sets ovf_err.
